// File: rtl/design_27_arb.sv
// Round-robin arbiter and sequencer in front of a shared design_27 datapath.
// Grants one requester per cycle, registers its operands onto the datapath,
// carries the requester id through a latency-matched tag pipeline and returns
// each result tagged with the requester that issued it.
module design_27_arb #(
  parameter  int W   = 12,
  parameter  int N   = 4,
  parameter  int LAT = 1,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  output logic [N-1:0]     req_ready,
  output logic             dp_start,
  output logic [W-1:0]     dp_a,
  output logic [W-1:0]     dp_b,
  input  logic [W-1:0]     dp_y,
  output logic             rsp_valid,
  output logic [IDW-1:0]   rsp_id,
  output logic [W-1:0]     rsp_y,
  output logic             busy
);

  localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);

  // One in-flight operation: whether the slot is occupied and who issued it.
  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0] ptr_q;
  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic [IDW:0]   scan_sum;
  logic [IDW-1:0] scan_idx;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;

  // Entry k holds the issue made k+1 cycles ago; entry LAT lines up with dp_y.
  tag_t tag_q [LAT+1];

  // Round-robin scan starting at ptr_q: first valid requester wins.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    req_ready   = '0;
    grant_found = 1'b0;
    grant_id    = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < N; k++) begin
      // NOTE: blocking assignments here so each iteration sees the value the
      // previous iteration just computed (first-match priority).
      scan_sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(N)) begin
        scan_sum = scan_sum - (IDW+1)'(N);
      end
      scan_idx = scan_sum[IDW-1:0];
      if (en && !grant_found && req_valid[scan_idx]) begin
        grant_found         = 1'b1;
        grant_id            = scan_idx;
        req_ready[scan_idx] = 1'b1;
      end
    end
  end

  // AND-OR operand mux driven by the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  // Issue stage: advance the RR pointer and register operands on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= '0;
      dp_start <= 1'b0;
      dp_a     <= '0;
      dp_b     <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register
      // samples pre-edge values regardless of statement order.
      dp_start <= grant_found;
      if (grant_found) begin
        ptr_q <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        dp_a  <= sel_a;
        dp_b  <= sel_b;
      end
    end
  end

  // Tag pipeline: shifts every cycle so the tag tracks its operation exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this small array is reset on purpose; a stale valid bit would
      // produce a phantom response after reset is released.
      for (int i = 0; i <= LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_t'{valid: grant_found, id: grant_id};
      for (int i = 1; i <= LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Response stage: capture dp_y with its tag; hold the payload when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
    end else begin
      rsp_valid <= tag_q[LAT].valid;
      if (tag_q[LAT].valid) begin
        rsp_id <= tag_q[LAT].id;
        rsp_y  <= dp_y;
      end
    end
  end

  // Busy while anything is issued, travelling through the datapath or returning.
  always_comb begin
    busy = dp_start | rsp_valid;
    for (int i = 0; i <= LAT; i++) begin
      busy = busy | tag_q[i].valid;
    end
  end

endmodule

// File: tb/tb_design_27_arb.sv
// Directed testbench for design_27_arb: a LAT=1 instance and a LAT=3 instance
// share the requester stimulus; each has a small datapath model producing
// dp_y = dp_a + dp_b for issued operations (0 otherwise) after LAT cycles.
module tb_design_27_arb;

  localparam int W   = 12;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;

  logic [N-1:0]   req_ready,  req_ready3;
  logic           dp_start,   dp_start3;
  logic [W-1:0]   dp_a,       dp_a3;
  logic [W-1:0]   dp_b,       dp_b3;
  logic [W-1:0]   dp_y,       dp_y3;
  logic           rsp_valid,  rsp_valid3;
  logic [IDW-1:0] rsp_id,     rsp_id3;
  logic [W-1:0]   rsp_y,      rsp_y3;
  logic           busy,       busy3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  design_27_arb #(.W(W), .N(N), .LAT(1)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b), .dp_y(dp_y),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .busy(busy)
  );

  design_27_arb #(.W(W), .N(N), .LAT(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready3),
    .dp_start(dp_start3), .dp_a(dp_a3), .dp_b(dp_b3), .dp_y(dp_y3),
    .rsp_valid(rsp_valid3), .rsp_id(rsp_id3), .rsp_y(rsp_y3), .busy(busy3)
  );

  // Datapath models: result only for issued operations, so misalignment shows.
  logic [W-1:0] y1_q;
  logic [W-1:0] y3_q [3];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y1_q <= '0;
      for (int i = 0; i < 3; i++) y3_q[i] <= '0;
    end else begin
      y1_q    <= dp_start  ? dp_a  + dp_b  : '0;
      y3_q[0] <= dp_start3 ? dp_a3 + dp_b3 : '0;
      y3_q[1] <= y3_q[0];
      y3_q[2] <= y3_q[1];
    end
  end
  assign dp_y  = y1_q;
  assign dp_y3 = y3_q[2];

  task automatic check(input logic ok, input string msg);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across two edges, release mid-cycle with all inputs idle.
  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Lane sums: a = 0x10*(i+1), b = i  ->  0x010, 0x021, 0x032, 0x043.
  task automatic load_lanes();
    req_a = {12'h040, 12'h030, 12'h020, 12'h010};
    req_b = {12'h003, 12'h002, 12'h001, 12'h000};
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    #3;
    check({req_ready, dp_start, dp_a, dp_b, rsp_valid, rsp_id, rsp_y, busy} === '0,
          $sformatf("reset_lat1: got %h expected 0",
                    {req_ready, dp_start, dp_a, dp_b, rsp_valid, rsp_id, rsp_y, busy}));
    check({req_ready3, dp_start3, dp_a3, dp_b3, rsp_valid3, rsp_id3, rsp_y3, busy3} === '0,
          $sformatf("reset_lat3: got %h expected 0",
                    {req_ready3, dp_start3, dp_a3, dp_b3, rsp_valid3, rsp_id3, rsp_y3, busy3}));
    step();
    rst = 1'b0;
    step();
    check({dp_start, rsp_valid, busy} === 3'b000,
          $sformatf("reset_idle: got %b expected 000", {dp_start, rsp_valid, busy}));
  endtask

  task automatic test_single();
    do_reset();
    en = 1'b1; req_valid = 4'b0100;
    req_a = {12'hA03, 12'h123, 12'hA01, 12'hA00};
    req_b = {12'hB03, 12'h011, 12'hB01, 12'hB00};
    #1;  // T
    check(req_ready === 4'b0100, $sformatf("single_grant: got %b expected 0100", req_ready));
    check(busy === 1'b0, $sformatf("single_busy_T: got %b expected 0", busy));
    step(); req_valid = '0; #1;  // T+1
    check({dp_start, dp_a, dp_b} === {1'b1, 12'h123, 12'h011},
          $sformatf("single_issue: got %h expected %h", {dp_start, dp_a, dp_b}, {1'b1, 12'h123, 12'h011}));
    check({busy, rsp_valid} === 2'b10,
          $sformatf("single_T1: got %b expected 10", {busy, rsp_valid}));
    step(); #1;  // T+2
    check({dp_start, rsp_valid, busy, dp_a} === {1'b0, 1'b0, 1'b1, 12'h123},
          $sformatf("single_T2: got %h expected %h", {dp_start, rsp_valid, busy, dp_a}, {3'b001, 12'h123}));
    step(); #1;  // T+3
    check({rsp_valid, rsp_id, rsp_y, busy} === {1'b1, 2'd2, 12'h134, 1'b1},
          $sformatf("single_rsp: got %h expected %h", {rsp_valid, rsp_id, rsp_y, busy}, {1'b1, 2'd2, 12'h134, 1'b1}));
    step(); #1;  // T+4
    check({rsp_valid, busy, rsp_id, rsp_y} === {1'b0, 1'b0, 2'd2, 12'h134},
          $sformatf("single_hold: got %h expected %h", {rsp_valid, busy, rsp_id, rsp_y}, {2'b00, 2'd2, 12'h134}));
  endtask

  task automatic test_all_four();
    logic [W-1:0] lane_a   [4] = '{12'h010, 12'h020, 12'h030, 12'h040};
    logic [W-1:0] lane_sum [4] = '{12'h010, 12'h021, 12'h032, 12'h043};
    do_reset();
    en = 1'b1; req_valid = 4'b1111; load_lanes();
    for (int k = 0; k < 9; k++) begin
      if (k > 0) step();
      #1;
      check(req_ready === (4'b0001 << (k % 4)),
            $sformatf("all4_grant c%0d: got %b expected %b", k, req_ready, 4'b0001 << (k % 4)));
      if (k >= 1) begin
        check({dp_start, dp_a} === {1'b1, lane_a[(k-1)%4]},
              $sformatf("all4_issue c%0d: got %h expected %h", k, {dp_start, dp_a}, {1'b1, lane_a[(k-1)%4]}));
      end
      if (k >= 3) begin
        check({rsp_valid, rsp_id, rsp_y} === {1'b1, 2'((k-3)%4), lane_sum[(k-3)%4]},
              $sformatf("all4_rsp c%0d: got %h expected %h", k, {rsp_valid, rsp_id, rsp_y},
                        {1'b1, 2'((k-3)%4), lane_sum[(k-3)%4]}));
      end
    end
    req_valid = '0;
  endtask

  task automatic test_fairness();
    do_reset();
    en = 1'b1; req_valid = 4'b1001; load_lanes();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      #1;
      check(req_ready === ((k % 2 == 0) ? 4'b0001 : 4'b1000),
            $sformatf("fair_grant c%0d: got %b expected %b", k, req_ready,
                      (k % 2 == 0) ? 4'b0001 : 4'b1000));
    end
    req_valid = '0;
  endtask

  task automatic test_en_low();
    logic [3:0] g_exp  [8] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    logic       ds_exp [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       rv_exp [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       bz_exp [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    en = 1'b1; req_valid = 4'b0011; load_lanes();
    for (int c = 0; c < 8; c++) begin
      if (c > 0) step();
      if (c == 2) begin en = 1'b0; req_valid = 4'b1111; end
      if (c == 7) en = 1'b1;
      #1;
      check({req_ready, dp_start, rsp_valid, busy} === {g_exp[c], ds_exp[c], rv_exp[c], bz_exp[c]},
            $sformatf("en_low c%0d: got %b expected %b", c, {req_ready, dp_start, rsp_valid, busy},
                      {g_exp[c], ds_exp[c], rv_exp[c], bz_exp[c]}));
      if (c == 3 || c == 4) begin
        check({rsp_id, rsp_y} === ((c == 3) ? {2'd0, 12'h010} : {2'd1, 12'h021}),
              $sformatf("en_low_rsp c%0d: got %h expected %h", c, {rsp_id, rsp_y},
                        (c == 3) ? {2'd0, 12'h010} : {2'd1, 12'h021}));
      end
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1; req_valid = 4'b0011; load_lanes();
    #1;
    check(req_ready === 4'b0001, $sformatf("rmid_g0: got %b expected 0001", req_ready));
    step(); #1;
    check(req_ready === 4'b0010, $sformatf("rmid_g1: got %b expected 0010", req_ready));
    step(); req_valid = '0; #1;  // T+2, second issue on the datapath
    check({dp_start, busy} === 2'b11, $sformatf("rmid_pre: got %b expected 11", {dp_start, busy}));
    rst = 1'b1;
    #1;
    check({req_ready, dp_start, dp_a, dp_b, rsp_valid, rsp_id, rsp_y, busy} === '0,
          $sformatf("rmid_async: got %h expected 0",
                    {req_ready, dp_start, dp_a, dp_b, rsp_valid, rsp_id, rsp_y, busy}));
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check({rsp_valid, busy} === 2'b00,
            $sformatf("rmid_quiet c%0d: got %b expected 00", k, {rsp_valid, busy}));
    end
    req_valid = 4'b1010;
    #1;
    check(req_ready === 4'b0010, $sformatf("rmid_ptr: got %b expected 0010", req_ready));
    step(); req_valid = '0; #1;
    check({dp_start, dp_a} === {1'b1, 12'h020},
          $sformatf("rmid_issue: got %h expected %h", {dp_start, dp_a}, {1'b1, 12'h020}));
  endtask

  task automatic test_lat3();
    do_reset();
    en = 1'b1; req_valid = 4'b0010;
    req_a = {12'h000, 12'h000, 12'h0AB, 12'h000};
    req_b = {12'h000, 12'h000, 12'h005, 12'h000};
    #1;  // T
    check(req_ready3 === 4'b0010, $sformatf("lat3_grant: got %b expected 0010", req_ready3));
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) req_valid = '0;
      #1;
      check({rsp_valid3, busy3} === {(c == 5), (c <= 5)},
            $sformatf("lat3_timing c%0d: got %b expected %b", c, {rsp_valid3, busy3},
                      {(c == 5), (c <= 5)}));
      if (c == 5) begin
        check({rsp_id3, rsp_y3} === {2'd1, 12'h0B0},
              $sformatf("lat3_rsp: got %h expected %h", {rsp_id3, rsp_y3}, {2'd1, 12'h0B0}));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_en_low();
    test_reset_mid();
    test_lat3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/design_27_arb.md
Name: design_27_arb

Overview:
- Round-robin arbiter and sequencer that shares one design_27 datapath (registered a/b operands, combinational core, y output) between N requesters.
- Accepts one operand pair per cycle from the winning requester and drives the datapath operands plus a start pulse.
- Tracks the requester ID of each in-flight operation through a latency-matched tag pipeline, then returns each result tagged with its originating requester.
- Sits between the requester cluster and the design_27 instance; the result path has no backpressure.

Parameters:
W, 12, operand/result width; must match the datapath W.
N, 4, number of requesters; 2..8.
LAT, 1, datapath latency in cycles from dp_a/dp_b driven to the matching dp_y being valid; 1..4.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  issue enable; when low, no new grants are made and in-flight operations still drain.
req_valid  input  N  per-requester request valid.
req_a  input  N*W  packed operand a; requester i occupies bits [i*W +: W].
req_b  input  N*W  packed operand b, same packing as req_a.
req_ready  output  N  one-hot or zero grant; combinational.
dp_start  output  1  one-cycle pulse to the datapath start input, registered.
dp_a  output  W  operand a to the datapath, registered.
dp_b  output  W  operand b to the datapath, registered.
dp_y  input  W  datapath result.
rsp_valid  output  1  result valid pulse, registered.
rsp_id  output  IDW  requester index of the result; IDW = max(1, clog2(N)).
rsp_y  output  W  result value.
busy  output  1  high while any operation is issued or in flight.

Behaviour:
Reset:
- Every output and internal register goes to 0.
- RR pointer = 0; tag pipeline is cleared.
- Assertion mid-operation discards all in-flight work; no rsp_valid is produced for it after release.

Arbitration:
- req_ready[i] = en && req_valid[i] && (i is the first valid index searching ptr, ptr+1, ... mod N).
- At most one bit of req_ready is set; it is 0 when en=0 or no request is valid.
- A transfer occurs when req_valid[i] && req_ready[i]. The requester holds req_valid and operands stable until the transfer, and must not derive req_valid from req_ready.
- On a transfer to i: ptr <= (i+1) mod N. With no transfer, ptr holds.

Issue (acceptance in cycle T):
- Cycle T+1: dp_a/dp_b = the accepted operands; dp_start = 1.
- When there is no transfer, dp_start = 0 and dp_a/dp_b hold their previous values.
- One issue per cycle is allowed (fully pipelined).

Tag pipeline:
- Shift register of depth LAT+1 carrying {valid, id}, aligned so that the entry for the T+1 issue reaches the output stage when dp_y for that issue is valid (cycle T+1+LAT).

Response:
- At the end of cycle T+1+LAT, rsp_y <= dp_y, rsp_id <= tag id, rsp_valid <= tag valid.
- rsp_valid is therefore high in cycle T+2+LAT (T+3 at default LAT).
- With no valid tag, rsp_valid = 0 and rsp_y/rsp_id hold.
- Results return in issue order.

busy:
- Combinational OR of the dp_start register, all tag-valid bits and rsp_valid.
- Low only when fully idle.

en:
- Deasserting en blocks new grants from the next evaluation and has no effect on in-flight operations.
- A requester waiting when en falls keeps req_valid high and wins once en returns, in RR order.

Width/wrap:
- Result width is W; the value is exactly the datapath output, with no extension or truncation in this block.
- ptr wraps from N-1 to 0.

Test Plan:
- Single request: reset, en=1, req_valid=4'b0100, a=12'h123, b=12'h011 -> req_ready=4'b0100 in T; dp_start in T+1 with dp_a=12'h123; rsp_valid in T+3 with rsp_id=2 and rsp_y equal to dp_y sampled in T+2; busy high in T+1..T+3.
- All four requesting continuously -> grants 0,1,2,3,0,1 in consecutive cycles; dp_start high every cycle; rsp_id sequence 0,1,2,3,0,1 starting at T+3.
- Fairness: requesters 0 and 3 held valid, ptr=0 -> grants alternate 0,3,0,3; requester 3 is never starved for more than 1 cycle.
- en low: req_valid=4'b1111 with en=0 for 5 cycles -> req_ready=0 and dp_start=0 throughout; in-flight results from before en fell still appear with correct ids.
- Reset mid-flight: two operations issued, rst pulsed in T+2 -> all outputs 0 immediately; no rsp_valid after release; ptr=0, so the first grant goes to the lowest valid index.
- LAT=3 build: single request -> rsp_valid exactly at T+5 and rsp_y matches the dp_y driven at T+4.
